mem_port_arbiter: RTL and testbench

// - Shares the single-port Memoria between two requesters: port 0 = CPU, port 1 = loader/debug DMA.
// - Port 0 serves the multicycle CPU's fetch and load/store. Port 1 serves program/data preload and debug access.
// - Serialises accesses, covers the fixed memory read latency, returns read data with a one-cycle ack.
// - Drives cpu_stall so the CPU's control FSM holds its state while it waits.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port Memoria: CPU on port 0, loader/debug DMA on port 1.
// Serialises accesses over a fixed read latency and returns a one-cycle registered ack per transaction.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_wr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       last_grant;
    logic       any_req;
    logic       pick_ldr;

    assign any_req = cpu_req | ldr_req;
    // Lock wins outright; on a tie the port that was not served last goes next.
    assign pick_ldr  = ldr_req & (ldr_lock | ~cpu_req | ~last_grant);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign busy      = (state != IDLE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (cnt == 3'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_addr   <= '0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= pick_ldr;
                        mem_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
                        mem_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
                        mem_wr    <= pick_ldr ? ldr_wr    : cpu_wr;
                        cnt       <= CNT_INIT;
                    end else begin
                        mem_wr <= 1'b0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        // mem_wr still carries the transaction direction on this last ACCESS cycle
                        mem_wr <= 1'b0;
                        if (grant) ldr_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                        if (!mem_wr) begin
                            if (grant) ldr_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                    end
                end
                RESP:    last_grant <= grant;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 instance with a RAM model,
// plus a MEM_LAT=3 instance whose read data only settles after the full latency.
module tb_mem_port_arbiter;
    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_wr, cpu_ack, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_wr, ldr_lock, ldr_ack;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, grant, busy;

    logic        m3_cpu_req, m3_cpu_wr, m3_cpu_ack, m3_cpu_stall;
    logic [31:0] m3_cpu_addr, m3_cpu_wdata, m3_cpu_rdata;
    logic        m3_ldr_req, m3_ldr_wr, m3_ldr_lock, m3_ldr_ack;
    logic [31:0] m3_ldr_addr, m3_ldr_wdata, m3_ldr_rdata;
    logic [31:0] m3_mem_addr, m3_mem_wdata, m3_mem_rdata;
    logic        m3_mem_wr, m3_grant, m3_busy;
    logic [31:0] m3_ad1, m3_ad2;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cycles;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(m3_cpu_req), .cpu_wr(m3_cpu_wr), .cpu_addr(m3_cpu_addr), .cpu_wdata(m3_cpu_wdata),
        .cpu_ack(m3_cpu_ack), .cpu_rdata(m3_cpu_rdata), .cpu_stall(m3_cpu_stall),
        .ldr_req(m3_ldr_req), .ldr_wr(m3_ldr_wr), .ldr_addr(m3_ldr_addr), .ldr_wdata(m3_ldr_wdata),
        .ldr_lock(m3_ldr_lock), .ldr_ack(m3_ldr_ack), .ldr_rdata(m3_ldr_rdata),
        .mem_addr(m3_mem_addr), .mem_wr(m3_mem_wr), .mem_wdata(m3_mem_wdata), .mem_rdata(m3_mem_rdata),
        .grant(m3_grant), .busy(m3_busy)
    );

    function automatic logic [31:0] init_val(input logic [7:0] idx);
        return {24'hA5C300, idx};
    endfunction

    // RAM model for the MEM_LAT=1 instance; loaded once, survives later resets
    logic [31:0] mem1 [256];
    bit          mem_ready;
    assign mem_rdata = mem1[mem_addr[9:2]];
    always @(posedge Clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem1[i] <= init_val(8'(i));
            mem_ready <= 1'b1;
        end else if (mem_wr) begin
            mem1[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // MEM_LAT=3 read path: data follows the address two edges late
    always @(posedge Clk) begin
        m3_ad1 <= m3_mem_addr;
        m3_ad2 <= m3_ad1;
    end
    assign m3_mem_rdata = init_val(m3_ad2[9:2]);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_ack(input bit port, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            n++;
            if (mem_wr) wr_cycles++;
            if (port ? ldr_ack : cpu_ack) got = 1'b1;
        end
        if (!got) chk("ack_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int n, nc, nl, k, cyc, overlap, stall_gap, acc, addr_bad, spur;
        logic [7:0] seq;

        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_wr = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
        m3_cpu_req = 0; m3_cpu_wr = 0; m3_cpu_addr = '0; m3_cpu_wdata = '0;
        m3_ldr_req = 0; m3_ldr_wr = 0; m3_ldr_addr = '0; m3_ldr_wdata = '0; m3_ldr_lock = 0;
        wr_cycles = 0;

        // reset state and first CPU read
        do_reset();
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_acks", {cpu_ack, ldr_ack}, 0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0;
        #1 chk("rd0_stall_c1", cpu_stall, 1);
        tick();
        chk("rd0_busy_c2", busy, 1);
        chk("rd0_addr_c2", mem_addr, 0);
        chk("rd0_ack_c2", cpu_ack, 0);
        chk("rd0_stall_c2", cpu_stall, 1);
        tick();
        chk("rd0_ack_c3", cpu_ack, 1);
        chk("rd0_ldr_ack_c3", ldr_ack, 0);
        chk("rd0_rdata", cpu_rdata, init_val(8'h00));
        chk("rd0_stall_c3", cpu_stall, 0);
        cpu_req = 0;
        tick();
        chk("rd0_ack_drop", cpu_ack, 0);
        chk("rd0_idle", busy, 0);

        // write 0x10 then read it back
        cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        wr_cycles = 0;
        wait_ack(1'b0, n);
        chk("wr_latency", n, 2);
        chk("wr_mem_wr_cycles", wr_cycles, 1);
        cpu_wr = 0;
        wait_ack(1'b0, n);
        chk("rd_after_wr_spacing", n, 3);
        chk("rd_after_wr_data", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 0;
        tick();

        // round-robin with both requesters held
        do_reset();
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h20;
        ldr_req = 1; ldr_wr = 0; ldr_addr = 32'h40;
        nc = 0; nl = 0; k = 0; cyc = 0; overlap = 0; seq = '0;
        while ((nc < 4 || nl < 4) && cyc < 100) begin
            tick();
            cyc++;
            if (cpu_ack && ldr_ack) overlap++;
            if (cpu_ack) begin
                if (k < 8) seq[k] = 1'b0;
                k++; nc++;
                chk("rr_cpu_rdata", cpu_rdata, init_val(8'h08));
                if (nc == 4) cpu_req = 0;
            end
            if (ldr_ack) begin
                if (k < 8) seq[k] = 1'b1;
                k++; nl++;
                chk("rr_ldr_rdata", ldr_rdata, init_val(8'h10));
                if (nl == 4) ldr_req = 0;
            end
        end
        chk("rr_order", seq, 8'b1010_1010);
        chk("rr_overlap", overlap, 0);
        chk("rr_counts", {nc[15:0], nl[15:0]}, {16'd4, 16'd4});
        chk("rr_cycles", cyc, 23);
        tick();

        // loader lock: three writes before the CPU read of the last written word
        do_reset();
        ldr_lock = 1; ldr_req = 1; ldr_wr = 1; ldr_addr = 32'h80; ldr_wdata = 32'h11110000;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h88;
        nl = 0; k = 0; cyc = 0; stall_gap = 0; seq = '0;
        while (cpu_req && cyc < 100) begin
            tick();
            cyc++;
            if (!cpu_ack && !cpu_stall) stall_gap++;
            if (ldr_ack) begin
                if (k < 8) seq[k] = 1'b1;
                k++; nl++;
                if (nl == 3) begin
                    ldr_req = 0; ldr_lock = 0;
                end else begin
                    ldr_addr = ldr_addr + 32'd4; ldr_wdata = ldr_wdata + 32'd1;
                end
            end
            if (cpu_ack) begin
                if (k < 8) seq[k] = 1'b0;
                k++;
                chk("lock_cpu_rdata", cpu_rdata, 32'h11110002);
                cpu_req = 0;
            end
        end
        chk("lock_order", seq, 8'b0000_0111);
        chk("lock_total", k, 4);
        chk("lock_stall_gap", stall_gap, 0);
        chk("lock_cycles", cyc, 11);
        tick();

        // reset in the middle of a loader write
        do_reset();
        ldr_req = 1; ldr_wr = 1; ldr_addr = 32'hC0; ldr_wdata = 32'hBAD0BAD0;
        tick();
        chk("abort_pre_wr", mem_wr, 1);
        chk("abort_pre_busy", busy, 1);
        #2 Reset = 1'b1;
        #1;
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_busy", busy, 0);
        ldr_req = 0;
        @(posedge Clk);
        #1 Reset = 1'b0;
        spur = 0;
        for (int i = 0; i < 3; i++) begin
            if (ldr_ack) spur++;
            tick();
        end
        chk("abort_no_ack", spur, 0);
        ldr_req = 1; ldr_wr = 0;
        wait_ack(1'b1, n);
        chk("abort_next_latency", n, 2);
        chk("abort_next_rdata", ldr_rdata, init_val(8'h30));
        chk("abort_next_grant", grant, 1);
        ldr_req = 0;
        tick();

        // MEM_LAT=3 read of 0x4
        m3_cpu_req = 1; m3_cpu_wr = 0; m3_cpu_addr = 32'h4;
        n = 0; acc = 0; addr_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (m3_busy && !m3_cpu_ack) begin
                acc++;
                if (m3_mem_addr != 32'h4) addr_bad++;
            end
            if (m3_cpu_ack) break;
        end
        m3_cpu_req = 0;
        chk("lat3_ack_cycle", n, 4);
        chk("lat3_access_cycles", acc, 3);
        chk("lat3_addr_stable", addr_bad, 0);
        chk("lat3_rdata", m3_cpu_rdata, init_val(8'h01));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
